seven_segment_counter_mux: RTL and testbench
============================================

Name: seven_segment_counter_mux

Overview:
Parametrised successor to the single-digit seconds display. Multi-digit up/down counter with selectable BCD or hex radix, a programmable tick prescaler, a time-multiplexed digit scan for a common-segment display, and optional leading-zero blanking. Sits directly behind the 8-bit user I/O: one clock, one reset, a few control pins in; segments plus one-hot digit selects out.

Parameters:
MAX_COUNT, 16_000_000, clock cycles per count step (>=1)
DIGITS, 2, number of displayed digits (1..4)
MUX_COUNT, 1024, clock cycles each digit stays selected during scan (>=1)
DECIMAL, 1, 1 = BCD digits 0-9; 0 = hex digits 0-F
LZB, 1, 1 = blank leading zero digits; digit 0 is never blanked

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
en  input  1  count enable; 0 freezes prescaler and value
up  input  1  1 = count up, 0 = count down
clear  input  1  synchronous clear of value and prescaler
segments  output  7  segment drive, bit0=a … bit6=g, active high
digit_sel  output  DIGITS  one-hot active-high select of the digit shown on segments
wrap  output  1  one-cycle pulse when value wraps at either end

Behaviour:
- Reset (rst=0, no clock needed): prescaler=0, value=0, scan index=0, wrap=0. Outputs: digit_sel=1 (digit 0), segments=0x3F.
- Prescaler: while en=1, increments each cycle. At MAX_COUNT-1 it asserts an internal tick and returns to 0. While en=0 it holds and no tick occurs. MAX_COUNT=1 gives a tick every enabled cycle.
- Value: DIGITS nibbles, updated only on tick.
  - up=1: increment digit 0; digit wraps 9->0 (DECIMAL=1) or F->0 (DECIMAL=0) with carry to the next digit.
  - up=0: decrement with borrow; 0 -> 9 or F.
  - Full wrap, up: all-max -> all-0. Full wrap, down: all-0 -> all-max. On that same edge wrap=1 for exactly one cycle, else wrap=0.
- clear=1: on the next edge, value=0 and prescaler=0. Overrides a coincident tick; wrap stays 0. Applies regardless of en.
- up changed mid-count: takes effect at the next tick; prescaler is not reset.
- Scan: a free-running counter (independent of en and clear) advances the scan index every MUX_COUNT cycles, 0..DIGITS-1 then back to 0. digit_sel = 1<<index. DIGITS=1: digit_sel is constantly 1.
- Segment decode, combinational from the registered value and scan index. Value/index changes appear on segments right after the updating edge, with no extra latency.
  - Digit codes 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- LZB=1: digit k>0 shows 0x00 when it and every higher digit are 0. LZB=0: all digits shown.
- Async reset mid-operation: all state returns to reset values immediately. Counting resumes from value 0 on the first edge after rst=1.

Test Plan:
1. Params MAX_COUNT=4, DIGITS=2, MUX_COUNT=2, DECIMAL=1, LZB=0. Hold rst=0 -> segments=0x3F, digit_sel=2'b01, wrap=0. Release -> digit_sel alternates 01/10 every 2 cycles.
2. en=1, up=1 for 40 cycles -> value=10. Digit_sel=10 shows 0x06; digit_sel=01 shows 0x3F. Set en=0 for 20 cycles -> value still 10.
3. Count up from 0 for 400 cycles -> 99 then 00. wrap high exactly one cycle, on the 99->00 edge.
4. From 0, up=0, en=1 -> after 4 cycles value=99 and a single wrap pulse. DECIMAL=0: from 0 -> FF; digit codes 0x71/0x71.
5. Drive clear=1 on the same cycle as a tick at value 42 -> value=00, prescaler=0, wrap=0. Next tick comes 4 enabled cycles later.
6. LZB=1 at value 05 -> digit 1 shows 0x00, digit 0 shows 0x6D. At value 00, digit 0 shows 0x3F. Pull rst low mid-count between clock edges -> outputs revert to reset values before the next edge.

Source files
------------

// File: rtl/seven_segment_counter_mux.sv
// Multi-digit BCD/hex up/down counter with prescaler, digit scan and
// leading-zero blanking. Ports: clk, rst (async low), en, up, clear -> segments, digit_sel, wrap.
module seven_segment_counter_mux #(
  parameter int MAX_COUNT = 16_000_000,
  parameter int DIGITS    = 2,
  parameter int MUX_COUNT = 1024,
  parameter int DECIMAL   = 1,
  parameter int LZB       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              clear,
  output logic [6:0]        segments,
  output logic [DIGITS-1:0] digit_sel,
  output logic              wrap
);

  localparam int PW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int MW = (MUX_COUNT > 1) ? $clog2(MUX_COUNT) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [3:0] DMAX = (DECIMAL != 0) ? 4'd9 : 4'd15;

  logic [PW-1:0]     presc;
  logic [VW-1:0]     value;
  logic [VW-1:0]     value_nxt;
  logic              carry;
  logic              tick;
  logic [3:0]        d;
  logic [MW-1:0]     mux_cnt;
  logic [IW-1:0]     idx;
  logic [DIGITS-1:0] blank;
  logic              hz;
  logic [3:0]        nib;

  assign tick = en && (presc == PW'(MAX_COUNT - 1));

  // Ripple carry/borrow; carry out of the top digit marks a full wrap.
  always_comb begin
    value_nxt = value;
    carry     = 1'b1;
    d         = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      d = value[k*4 +: 4];
      if (carry) begin
        if (up) begin
          if (d == DMAX) begin
            value_nxt[k*4 +: 4] = 4'd0;
          end else begin
            value_nxt[k*4 +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            value_nxt[k*4 +: 4] = DMAX;
          end else begin
            value_nxt[k*4 +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      value <= '0;
      wrap  <= 1'b0;
    end else if (clear) begin
      presc <= '0;
      value <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= tick && carry;
      if (en) presc <= tick ? '0 : presc + PW'(1);
      if (tick) value <= value_nxt;
    end
  end

  // Scan runs free of en/clear so the display never stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mux_cnt <= '0;
      idx     <= '0;
    end else if (mux_cnt == MW'(MUX_COUNT - 1)) begin
      mux_cnt <= '0;
      idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      mux_cnt <= mux_cnt + MW'(1);
    end
  end

  // A digit blanks when it and all digits above it are zero.
  always_comb begin
    hz    = 1'b1;
    blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hz = hz && (value[k*4 +: 4] == 4'd0);
      blank[k] = (LZB != 0) && (k != 0) && hz;
    end
  end

  assign nib       = value[{idx, 2'b00} +: 4];
  assign digit_sel = DIGITS'(1) << idx;

  always_comb begin
    segments = 7'h00;
    if (!blank[idx]) begin
      case (nib)
        4'h0: segments = 7'h3F;
        4'h1: segments = 7'h06;
        4'h2: segments = 7'h5B;
        4'h3: segments = 7'h4F;
        4'h4: segments = 7'h66;
        4'h5: segments = 7'h6D;
        4'h6: segments = 7'h7D;
        4'h7: segments = 7'h07;
        4'h8: segments = 7'h7F;
        4'h9: segments = 7'h6F;
        4'hA: segments = 7'h77;
        4'hB: segments = 7'h7C;
        4'hC: segments = 7'h39;
        4'hD: segments = 7'h5E;
        4'hE: segments = 7'h79;
        4'hF: segments = 7'h71;
        default: segments = 7'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Scoreboard bench: a decimal/no-blanking and a hex/blanking instance
// share stimulus and are checked against an arithmetic counter model.
module tb_seven_segment_counter_mux;

  localparam int MC = 4;
  localparam int D  = 2;
  localparam int MX = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic up = 1'b1;
  logic clear = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic [D-1:0] sel_a, sel_b;
  logic wrap_a, wrap_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seven_segment_counter_mux #(
    .MAX_COUNT(MC), .DIGITS(D), .MUX_COUNT(MX), .DECIMAL(1), .LZB(0)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear),
    .segments(seg_a), .digit_sel(sel_a), .wrap(wrap_a)
  );

  seven_segment_counter_mux #(
    .MAX_COUNT(MC), .DIGITS(D), .MUX_COUNT(MX), .DECIMAL(0), .LZB(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear),
    .segments(seg_b), .digit_sel(sel_b), .wrap(wrap_b)
  );

  typedef struct packed {
    logic [6:0]   seg;
    logic [D-1:0] sel;
    logic         wrap;
  } obs_t;

  obs_t qa[$];
  obs_t qb[$];

  int base[2] = '{10, 16};
  bit lzb[2]  = '{1'b0, 1'b1};
  int m_val[2];
  int m_pc[2];
  bit m_wrap[2];
  int m_n;

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                           7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                           7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i]  = 0;
      m_pc[i]   = 0;
      m_wrap[i] = 1'b0;
    end
    m_n = 0;
  endfunction

  // One clock edge: value is an integer mod base^D.
  function automatic void model_step(bit e, bit u, bit c);
    int n;
    for (int i = 0; i < 2; i++) begin
      n = base[i] ** D;
      m_wrap[i] = 1'b0;
      if (c) begin
        m_val[i] = 0;
        m_pc[i]  = 0;
      end else if (e) begin
        m_pc[i]++;
        if (m_pc[i] == MC) begin
          m_pc[i] = 0;
          if (u) begin
            m_wrap[i] = (m_val[i] == n - 1);
            m_val[i]  = (m_val[i] + 1) % n;
          end else begin
            m_wrap[i] = (m_val[i] == 0);
            m_val[i]  = (m_val[i] + n - 1) % n;
          end
        end
      end
    end
    m_n++;
  endfunction

  function automatic obs_t expect_obs(int i);
    obs_t o;
    int idx;
    int p;
    int digit;
    idx = (m_n / MX) % D;
    p = base[i] ** idx;
    digit = (m_val[i] / p) % base[i];
    o.sel  = D'(1) << idx;
    o.wrap = m_wrap[i];
    o.seg  = (lzb[i] && idx > 0 && m_val[i] < p) ? 7'h00 : lut[digit];
    return o;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got seg=%h sel=%b wrap=%b, want seg=%h sel=%b wrap=%b",
               name, $time, act.seg, act.sel, act.wrap, exp.seg, exp.sel, exp.wrap);
    end
  endtask

  task automatic check_reset(string name);
    obs_t r;
    r.seg = 7'h3F;
    r.sel = D'(1);
    r.wrap = 1'b0;
    check({name, "_a"}, {seg_a, sel_a, wrap_a}, r);
    check({name, "_b"}, {seg_b, sel_b, wrap_b}, r);
  endtask

  // Apply inputs for one cycle, then record what the edge should produce.
  task automatic cyc(bit e, bit u, bit c);
    en = e;
    up = u;
    clear = c;
    @(posedge clk);
    model_step(e, u, c);
    qa.push_back(expect_obs(0));
    qb.push_back(expect_obs(1));
    #1;
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) check("dec_lzb0", {seg_a, sel_a, wrap_a}, qa.pop_front());
    if (qb.size() > 0) check("hex_lzb1", {seg_b, sel_b, wrap_b}, qb.pop_front());
  end

  initial begin
    bit ru;
    model_reset();
    #2;
    check_reset("reset_noclk");
    repeat (2) @(negedge clk);
    check_reset("reset_held");
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    repeat (40) cyc(1'b1, 1'b1, 1'b0);
    repeat (20) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    repeat (420) cyc(1'b1, 1'b1, 1'b0);

    cyc(1'b1, 1'b0, 1'b1);
    repeat (12) cyc(1'b1, 1'b0, 1'b0);

    cyc(1'b1, 1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    repeat (8) cyc(1'b1, 1'b1, 1'b0);

    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    #3;
    rst = 1'b0;
    qa.delete();
    qb.delete();
    model_reset();
    #1;
    check_reset("reset_async");
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    ru = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 99) < 2) ru = ~ru;
      cyc($urandom_range(0, 99) < 85, ru, $urandom_range(0, 199) < 3);
    end

    repeat (2) @(negedge clk);
    tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
